mult_div_unit: RTL and testbench
================================

# mult_div_unit

Iterative multiply/divide unit with HI/LO result registers, sitting in the execute stage directly downstream of the register bank: it consumes the two operand buses read from the bank and produces the MIPS HI/LO pair used by MFHI/MFLO. It executes MULT, MULTU, DIV and DIVU in a fixed 34-cycle sequence using a radix-2 shift-add / restoring-divide datapath. It also services MTHI/MTLO writes and exposes busy/done so the hazard logic can stall on HI/LO readers.

## Interface
- No parameters; data width fixed at 32 bits, result 64 bits (HI:LO).
- clock  in  1  single system clock, all state updates on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request a new operation; sampled only in IDLE.
- op  in  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
- operand_a  in  32  rs value from the register bank (multiplicand / dividend).
- operand_b  in  32  rt value from the register bank (multiplier / divisor).
- hi_write  in  1  MTHI: load write_data into hi.
- lo_write  in  1  MTLO: load write_data into lo.
- write_data  in  32  data for MTHI/MTLO.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse when hi/lo receive a new result.
- hi  out  32  HI register (product upper word / remainder).
- lo  out  32  LO register (product lower word / quotient).

## Operation
- Reset (reset_n low, any time, including mid-operation): state IDLE, busy=0, done=0, hi=0, lo=0, iteration counter=0; in-flight operation discarded.
- States: IDLE -> RUN -> FIX -> IDLE.
- IDLE: if start=1, latch op, sign flags and operand magnitudes (absolute value for signed ops, raw for unsigned), clear 64-bit accumulator, counter=0, go RUN. start has priority over hi_write/lo_write in the same cycle (the writes are dropped). Otherwise hi_write/lo_write load write_data into hi/lo (both may fire together).
- RUN: exactly 32 iterations, one per cycle, counter 0..31; at counter=31 go FIX. start, hi_write, lo_write are ignored (no queueing).
- Multiply: unsigned shift-add of magnitudes into 64-bit accumulator.
- Divide: restoring division of magnitudes; 33-bit partial-remainder subtract each iteration, quotient bit shifted in.
- FIX: apply signs, write hi/lo, pulse done, go IDLE.
- MULT sign: negate 64-bit product if sign(a) XOR sign(b).
- DIV signs: quotient negated if sign(a) XOR sign(b); remainder takes sign of dividend. 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0 (wraps, no trap).
- Divide by zero (DIV or DIVU, operand_b=0): lo=0xFFFFFFFF, hi=operand_a as latched, same 34-cycle timing, no exception.
- Operand bus changes after the start cycle have no effect.

## Timing
- Edge E0: start sampled high in IDLE; busy=1 from after E0.
- Edges E1..E32: iterations 0..31.
- Edge E33: hi/lo updated, done=1 and busy=0 for the cycle following E33; done=0 after E34.
- Back-to-back: start may be asserted in the cycle where done=1; it is accepted at E34.
- MTHI/MTLO latency: one edge; value visible on hi/lo the cycle after.
- hi/lo are stable (hold previous values) throughout RUN.
- busy and done are registered outputs; no combinational path from inputs.

## Test plan
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> after 34 cycles hi=0xFFFFFFFE, lo=0x00000001, single done pulse, busy high exactly 33 cycles.
- MULT 0xFFFFFFFD (-3) x 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; DIV 0xFFFFFFF9 (-7) / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU 100 / 0 -> lo=0xFFFFFFFF, hi=0x00000064; DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- start and hi_write during RUN, operand buses toggled -> ignored; result unchanged; in IDLE, hi_write=lo_write=1 with 0x12345678 -> both hi and lo = 0x12345678 next cycle; start+lo_write same cycle -> lo_write dropped.
- reset_n pulsed low at iteration 15 of DIVU 1000/7 -> busy, done, hi, lo all 0 immediately; new DIVU 1000/7 then yields lo=142, hi=6.
- start held high continuously -> operations accepted every 34 cycles, done pulse each time, no lost or duplicated results.

Source files
------------

// File: rtl/mult_div_unit.sv
// Iterative 32-bit multiply/divide unit producing the MIPS HI/LO pair.
// Fixed 34-edge sequence: accept, 32 radix-2 iterations, sign fix-up.
`timescale 1ns/1ps
module mult_div_unit (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    input  logic        hi_write,
    input  logic        lo_write,
    input  logic [31:0] write_data,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

    state_e      state_q, state_d;
    logic [4:0]  count_q, count_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] mag_a_q, mag_a_d;
    logic [31:0] mag_b_q, mag_b_d;
    logic        is_div_q, is_div_d;
    logic        neg_q, neg_d;
    logic        a_neg_q, a_neg_d;
    logic        div_zero_q, div_zero_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic        start_a_neg, start_b_neg;
    logic [32:0] mul_sum;
    logic [32:0] div_shift;
    logic [32:0] div_diff;
    logic [63:0] product;
    logic [31:0] quotient;
    logic [31:0] remainder;

    assign start_a_neg = ~op[0] & operand_a[31];
    assign start_b_neg = ~op[0] & operand_b[31];

    // Multiply: add into the upper half, then shift the whole accumulator right.
    assign mul_sum   = {1'b0, acc_q[63:32]} + (mag_b_q[0] ? {1'b0, mag_a_q} : 33'd0);
    // Divide: partial remainder lives in acc[63:32], quotient bits enter acc[31:0].
    assign div_shift = {acc_q[63:32], mag_a_q[31]};
    assign div_diff  = div_shift - {1'b0, mag_b_q};

    assign product   = neg_q ? (64'd0 - acc_q) : acc_q;
    assign quotient  = div_zero_q ? 32'hFFFF_FFFF : (neg_q ? (32'd0 - acc_q[31:0]) : acc_q[31:0]);
    assign remainder = a_neg_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (start) state_d = StRun;
            StRun:   if (count_q == 5'd31) state_d = StFix;
            StFix:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        count_d    = count_q;
        acc_d      = acc_q;
        mag_a_d    = mag_a_q;
        mag_b_d    = mag_b_q;
        is_div_d   = is_div_q;
        neg_d      = neg_q;
        a_neg_d    = a_neg_q;
        div_zero_d = div_zero_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;
        busy_d     = (state_d != StIdle);
        case (state_q)
            StIdle: begin
                if (start) begin
                    is_div_d   = op[1];
                    neg_d      = start_a_neg ^ start_b_neg;
                    a_neg_d    = start_a_neg;
                    div_zero_d = (operand_b == 32'd0);
                    mag_a_d    = start_a_neg ? (32'd0 - operand_a) : operand_a;
                    mag_b_d    = start_b_neg ? (32'd0 - operand_b) : operand_b;
                    acc_d      = 64'd0;
                    count_d    = 5'd0;
                end else begin
                    if (hi_write) hi_d = write_data;
                    if (lo_write) lo_d = write_data;
                end
            end
            StRun: begin
                count_d = count_q + 5'd1;
                if (is_div_q) begin
                    mag_a_d = {mag_a_q[30:0], 1'b0};
                    if (!div_diff[32]) begin
                        acc_d = {div_diff[31:0], acc_q[30:0], 1'b1};
                    end else begin
                        acc_d = {div_shift[31:0], acc_q[30:0], 1'b0};
                    end
                end else begin
                    mag_b_d = {1'b0, mag_b_q[31:1]};
                    acc_d   = {mul_sum, acc_q[31:1]};
                end
            end
            StFix: begin
                done_d = 1'b1;
                if (is_div_q) begin
                    hi_d = remainder;
                    lo_d = quotient;
                end else begin
                    hi_d = product[63:32];
                    lo_d = product[31:0];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q    <= 5'd0;
            acc_q      <= 64'd0;
            mag_a_q    <= 32'd0;
            mag_b_q    <= 32'd0;
            is_div_q   <= 1'b0;
            neg_q      <= 1'b0;
            a_neg_q    <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= 32'd0;
            lo_q       <= 32'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            count_q    <= count_d;
            acc_q      <= acc_d;
            mag_a_q    <= mag_a_d;
            mag_b_q    <= mag_b_d;
            is_div_q   <= is_div_d;
            neg_q      <= neg_d;
            a_neg_q    <= a_neg_d;
            div_zero_q <= div_zero_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit.
`timescale 1ns/1ps
module tb_mult_div_unit;

    logic        clock;
    logic        reset_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        hi_write;
    logic        lo_write;
    logic [31:0] write_data;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    mult_div_unit dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .start      (start),
        .op         (op),
        .operand_a  (operand_a),
        .operand_b  (operand_b),
        .hi_write   (hi_write),
        .lo_write   (lo_write),
        .write_data (write_data),
        .busy       (busy),
        .done       (done),
        .hi         (hi),
        .lo         (lo)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One operation from start to done; optionally disturbs inputs while running.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo, input bit disturb, input bit with_lo_write);
        logic [31:0] prev_hi, prev_lo;
        int cycles, busy_cycles;
        bit held;
        @(negedge clock);
        prev_hi = hi;
        prev_lo = lo;
        start = 1'b1; op = o; operand_a = a; operand_b = b;
        lo_write = with_lo_write; write_data = 32'hDEAD_BEEF;
        @(negedge clock);
        start = 1'b0; lo_write = 1'b0;
        cycles = 0; busy_cycles = 0; held = 1'b1;
        while (!done && cycles < 40) begin
            if (busy) busy_cycles++;
            if (hi !== prev_hi || lo !== prev_lo) held = 1'b0;
            if (disturb) begin
                start      = cycles[0];
                hi_write   = 1'b1;
                lo_write   = ~cycles[0];
                write_data = $urandom;
                operand_a  = $urandom;
                operand_b  = $urandom;
                op         = 2'($urandom);
            end
            @(negedge clock);
            cycles++;
        end
        start = 1'b0; hi_write = 1'b0; lo_write = 1'b0;
        check({tag, " latency"}, 64'(cycles), 64'd33);
        check({tag, " busy_cycles"}, 64'(busy_cycles), 64'd33);
        check({tag, " hi"}, {32'd0, hi}, {32'd0, exp_hi});
        check({tag, " lo"}, {32'd0, lo}, {32'd0, exp_lo});
        check({tag, " hilo_held"}, {63'd0, held}, 64'd1);
        check({tag, " busy_at_done"}, {63'd0, busy}, 64'd0);
        @(negedge clock);
        check({tag, " done_pulse"}, {63'd0, done}, 64'd0);
    endtask

    logic [31:0] a_v [3];
    logic [31:0] b_v [3];
    logic [63:0] p_v [3];
    int k;

    initial begin
        reset_n = 1'b0; start = 1'b0; op = 2'd0; operand_a = 32'd0; operand_b = 32'd0;
        hi_write = 1'b0; lo_write = 1'b0; write_data = 32'd0;
        repeat (2) @(negedge clock);
        check("reset busy", {63'd0, busy}, 64'd0);
        check("reset done", {63'd0, done}, 64'd0);
        check("reset hilo", {hi, lo}, 64'd0);
        reset_n = 1'b1;

        run_op("multu max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0, 0);
        run_op("mult neg", 2'b00, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0, 0);
        run_op("div neg", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 0);
        run_op("div negdivisor", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 0, 0);
        run_op("divu zero", 2'b11, 32'd100, 32'd0, 32'h0000_0064, 32'hFFFF_FFFF, 0, 0);
        run_op("div zero", 2'b10, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 0, 0);
        run_op("div overflow", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 0, 0);
        run_op("multu disturbed", 2'b01, 32'd6, 32'd7, 32'd0, 32'd42, 1, 0);

        // MTHI and MTLO together in IDLE
        @(negedge clock);
        hi_write = 1'b1; lo_write = 1'b1; write_data = 32'h1234_5678;
        @(negedge clock);
        hi_write = 1'b0; lo_write = 1'b0;
        check("mthi", {32'd0, hi}, 64'h0000_0000_1234_5678);
        check("mtlo", {32'd0, lo}, 64'h0000_0000_1234_5678);

        // lo_write alongside start is dropped; hilo_held covers it
        run_op("start+mtlo", 2'b01, 32'd2, 32'd3, 32'd0, 32'd6, 0, 1);

        // Asynchronous reset mid-division
        @(negedge clock);
        start = 1'b1; op = 2'b11; operand_a = 32'd1000; operand_b = 32'd7;
        @(negedge clock);
        start = 1'b0;
        repeat (15) @(negedge clock);
        check("pre-reset busy", {63'd0, busy}, 64'd1);
        reset_n = 1'b0;
        #1;
        check("midop reset busy", {63'd0, busy}, 64'd0);
        check("midop reset done", {63'd0, done}, 64'd0);
        check("midop reset hilo", {hi, lo}, 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        run_op("divu after reset", 2'b11, 32'd1000, 32'd7, 32'd6, 32'd142, 0, 0);

        // start held high: one result every 34 cycles
        a_v[0] = 32'd3;      b_v[0] = 32'd5;        p_v[0] = 64'd15;
        a_v[1] = 32'd1000;   b_v[1] = 32'd1000;     p_v[1] = 64'd1000000;
        a_v[2] = 32'h0000_FFFF; b_v[2] = 32'h0001_0001; p_v[2] = 64'h0000_0000_FFFF_FFFF;
        k = 0;
        @(negedge clock);
        start = 1'b1; op = 2'b01; operand_a = a_v[0]; operand_b = b_v[0];
        for (int c = 1; c <= 102; c++) begin
            @(negedge clock);
            if (done) begin
                if (k < 3) begin
                    check($sformatf("b2b%0d spacing", k), 64'(c), 64'(34 * (k + 1)));
                    check($sformatf("b2b%0d hilo", k), {hi, lo}, p_v[k]);
                end
                k++;
                if (k < 3) begin
                    operand_a = a_v[k];
                    operand_b = b_v[k];
                end else begin
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        check("b2b count", 64'(k), 64'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
